// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I control FSM.
// Included by multicycle_control and mc_ctrl_outdec.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWRITE,
      MEMWB,
      EXECUTER,
      EXECUTEI,
      ALUWB,
      BEQ,
      JAL
   } state_t;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic ADR_PC     = 1'b0;
   localparam logic ADR_RESULT = 1'b1;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decoder for the multicycle control FSM (state, mem_ready, zero -> datapath controls).
// Optional JAL state outputs are built only when MC_CTRL_JAL_EN is defined.
module mc_ctrl_outdec
   import mc_ctrl_pkg::*;
(
   input  logic [3:0] i_state,
   input  logic       i_memReady,
   input  logic       i_zero,
   output logic [1:0] o_aluOp,
   output logic [1:0] o_aluSrcA,
   output logic [1:0] o_aluSrcB,
   output logic [1:0] o_resultSrc,
   output logic       o_adrSrc,
   output logic       o_memRead,
   output logic       o_memWrite,
   output logic       o_irWrite,
   output logic       o_pcWrite,
   output logic       o_regWrite
);

   // Every control defaults to its inactive/zero encoding; each state raises only what it needs.
   always_comb begin
      o_aluOp     = ALUOP_ADD;
      o_aluSrcA   = SRCA_PC;
      o_aluSrcB   = SRCB_RS2;
      o_resultSrc = RES_ALUOUT;
      o_adrSrc    = ADR_PC;
      o_memRead   = 1'b0;
      o_memWrite  = 1'b0;
      o_irWrite   = 1'b0;
      o_pcWrite   = 1'b0;
      o_regWrite  = 1'b0;
      case (state_t'(i_state))
         FETCH: begin
            o_memRead   = 1'b1;
            o_aluSrcB   = SRCB_FOUR;
            o_resultSrc = RES_ALURESULT;
            o_irWrite   = i_memReady;
            o_pcWrite   = i_memReady;
         end
         DECODE: begin
            o_aluSrcA = SRCA_OLDPC;
            o_aluSrcB = SRCB_IMM;
         end
         MEMADR: begin
            o_aluSrcA = SRCA_RS1;
            o_aluSrcB = SRCB_IMM;
         end
         MEMREAD: begin
            o_adrSrc  = ADR_RESULT;
            o_memRead = 1'b1;
         end
         MEMWRITE: begin
            o_adrSrc   = ADR_RESULT;
            o_memWrite = 1'b1;
         end
         MEMWB: begin
            o_resultSrc = RES_MEMDATA;
            o_regWrite  = 1'b1;
         end
         EXECUTER: begin
            o_aluSrcA = SRCA_RS1;
            o_aluOp   = ALUOP_FUNCT;
         end
         EXECUTEI: begin
            o_aluSrcA = SRCA_RS1;
            o_aluSrcB = SRCB_IMM;
            o_aluOp   = ALUOP_FUNCT;
         end
         ALUWB: begin
            o_regWrite = 1'b1;
         end
         BEQ: begin
            o_aluSrcA = SRCA_RS1;
            o_aluOp   = ALUOP_SUB;
            o_pcWrite = i_zero;
         end
`ifdef MC_CTRL_JAL_EN
         // ALUOut already holds the jump target computed in DECODE.
         JAL: begin
            o_aluSrcA = SRCA_OLDPC;
            o_aluSrcB = SRCB_FOUR;
            o_pcWrite = 1'b1;
         end
`endif
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I core: state register, next-state logic, reset gating.
// Define MC_CTRL_JAL_EN to build the JAL state; otherwise opcode 1101111 decodes as illegal.
module multicycle_control
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [1:0] ALUOp,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic       adr_src,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic       illegal_instr,
   output logic       instr_done
);

   state_t     r_state;
   state_t     w_nextState;
   logic       w_illegal;
   logic [1:0] w_aluOp, w_aluSrcA, w_aluSrcB, w_resultSrc;
   logic       w_adrSrc, w_memRead, w_memWrite, w_irWrite, w_pcWrite, w_regWrite;

   // State register; reset is synchronous and returns to FETCH from anywhere.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= FETCH;
      else        r_state <= w_nextState;
   end

   // Next-state logic; memory states hold until mem_ready, DECODE dispatches on the opcode.
   always_comb begin
      w_nextState = r_state;
      w_illegal   = 1'b0;
      case (r_state)
         FETCH:    if (mem_ready) w_nextState = DECODE;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: w_nextState = MEMADR;
               OP_RTYPE:     w_nextState = EXECUTER;
               OP_IALU:      w_nextState = EXECUTEI;
               OP_BEQ:       w_nextState = BEQ;
`ifdef MC_CTRL_JAL_EN
               OP_JAL:       w_nextState = JAL;
`endif
               default: begin
                  w_nextState = FETCH;
                  w_illegal   = 1'b1;
               end
            endcase
         end
         MEMADR:   w_nextState = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  if (mem_ready) w_nextState = MEMWB;
         MEMWRITE: if (mem_ready) w_nextState = FETCH;
         EXECUTER: w_nextState = ALUWB;
         EXECUTEI: w_nextState = ALUWB;
`ifdef MC_CTRL_JAL_EN
         JAL:      w_nextState = ALUWB;
`endif
         MEMWB:    w_nextState = FETCH;
         ALUWB:    w_nextState = FETCH;
         BEQ:      w_nextState = FETCH;
         default:  w_nextState = FETCH;
      endcase
   end

   mc_ctrl_outdec u_outdec (
      .i_state     (r_state),
      .i_memReady  (mem_ready),
      .i_zero      (zero),
      .o_aluOp     (w_aluOp),
      .o_aluSrcA   (w_aluSrcA),
      .o_aluSrcB   (w_aluSrcB),
      .o_resultSrc (w_resultSrc),
      .o_adrSrc    (w_adrSrc),
      .o_memRead   (w_memRead),
      .o_memWrite  (w_memWrite),
      .o_irWrite   (w_irWrite),
      .o_pcWrite   (w_pcWrite),
      .o_regWrite  (w_regWrite)
   );

   // Held reset silences every control so the memory sees no request before release.
   assign ALUOp         = rst_n ? w_aluOp     : 2'b00;
   assign alu_src_a     = rst_n ? w_aluSrcA   : 2'b00;
   assign alu_src_b     = rst_n ? w_aluSrcB   : 2'b00;
   assign result_src    = rst_n ? w_resultSrc : 2'b00;
   assign adr_src       = rst_n & w_adrSrc;
   assign mem_read      = rst_n & w_memRead;
   assign mem_write     = rst_n & w_memWrite;
   assign ir_write      = rst_n & w_irWrite;
   assign pc_write      = rst_n & w_pcWrite;
   assign reg_write     = rst_n & w_regWrite;
   assign illegal_instr = rst_n & w_illegal;
   // Waiting in FETCH is not the tail of an instruction, so it never flags completion.
   assign instr_done    = rst_n & (r_state != FETCH) & (w_nextState == FETCH);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, reset/wait sequences,
// then randomized instructions checked against a per-instruction step-plan model.
module tb_multicycle_control;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IA = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
`ifdef MC_CTRL_JAL_EN
   localparam bit JAL_EN = 1'b1;
`else
   localparam bit JAL_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, zero, mem_ready;
   logic [6:0] opcode;
   logic [1:0] ALUOp, alu_src_a, alu_src_b, result_src;
   logic       adr_src, mem_read, mem_write, ir_write, pc_write, reg_write;
   logic       illegal_instr, instr_done;

   int assertCount = 0;
   int failCount   = 0;

   typedef struct packed {
      logic [1:0] aluOp, srcA, srcB, resSrc;
      logic       adr, rd, wr, irw, pcw, regw, ill, done;
   } outs_t;

   typedef struct {
      logic       rn;
      logic [6:0] op;
      logic       mr;
      logic       z;
      outs_t      exp;
      string      name;
   } vec_t;

   typedef enum {SK_FETCH, SK_DECODE, SK_ADDR, SK_LOAD, SK_STORE, SK_LOADWB,
                 SK_EXEC_R, SK_EXEC_I, SK_ALUWB, SK_BRANCH, SK_JUMP} step_e;

   multicycle_control dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .ALUOp         (ALUOp),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .result_src    (result_src),
      .adr_src       (adr_src),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .reg_write     (reg_write),
      .illegal_instr (illegal_instr),
      .instr_done    (instr_done)
   );

   function automatic outs_t mk(input logic [1:0] aluOp, srcA, srcB, resSrc,
                                input logic adr, rd, wr, irw, pcw, regw, ill, done);
      outs_t o;
      o.aluOp = aluOp; o.srcA = srcA; o.srcB = srcB; o.resSrc = resSrc;
      o.adr = adr; o.rd = rd; o.wr = wr; o.irw = irw;
      o.pcw = pcw; o.regw = regw; o.ill = ill; o.done = done;
      return o;
   endfunction

   // Expected controls for one step of an instruction, straight from the output table.
   function automatic outs_t stepOut(input step_e s, input logic mr, input logic z,
                                     input logic ill, input logic last);
      case (s)
         SK_FETCH:  return mk(2'd0, 2'd0, 2'd2, 2'd2, 0, 1, 0, mr, mr, 0, 0, last);
         SK_DECODE: return mk(2'd0, 2'd1, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0, ill, last);
         SK_ADDR:   return mk(2'd0, 2'd2, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0, last);
         SK_LOAD:   return mk(2'd0, 2'd0, 2'd0, 2'd0, 1, 1, 0, 0, 0, 0, 0, last);
         SK_STORE:  return mk(2'd0, 2'd0, 2'd0, 2'd0, 1, 0, 1, 0, 0, 0, 0, last);
         SK_LOADWB: return mk(2'd0, 2'd0, 2'd0, 2'd1, 0, 0, 0, 0, 0, 1, 0, last);
         SK_EXEC_R: return mk(2'd2, 2'd2, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, last);
         SK_EXEC_I: return mk(2'd2, 2'd2, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0, last);
         SK_ALUWB:  return mk(2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, last);
         SK_BRANCH: return mk(2'd1, 2'd2, 2'd0, 2'd0, 0, 0, 0, 0, z, 0, 0, last);
         default:   return mk(2'd0, 2'd1, 2'd2, 2'd0, 0, 0, 0, 0, 1, 0, 0, last);
      endcase
   endfunction

   // Cycles per instruction with no memory waits.
   function automatic int cpi(input logic [6:0] op);
      case (op)
         LW:             return 5;
         SW, RT, IA:     return 4;
         BQ:             return 3;
         JL:             return JAL_EN ? 4 : 2;
         default:        return 2;
      endcase
   endfunction

   task automatic applyStimulus(input logic rn, input logic [6:0] op, input logic mr, input logic z);
      rst_n = rn; opcode = op; mem_ready = mr; zero = z;
   endtask

   task automatic checkOutput(input string name, input outs_t expected, output logic dutDone);
      outs_t actual;
      actual = {ALUOp, alu_src_a, alu_src_b, result_src, adr_src, mem_read, mem_write,
                ir_write, pc_write, reg_write, illegal_instr, instr_done};
      dutDone = instr_done;
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: actual=%b required=%b", name, actual, expected);
      end
   endtask

   task automatic runCycle(input logic rn, input logic [6:0] op, input logic mr, input logic z,
                           input string name, input outs_t expected, output logic dutDone);
      @(posedge clk);
      #1;
      applyStimulus(rn, op, mr, z);
      @(negedge clk);
      checkOutput(name, expected, dutDone);
   endtask

   vec_t  vecs[$];
   step_e plan[$];

   task automatic addVec(input logic rn, input logic [6:0] op, input logic mr, input logic z,
                         input string name, input outs_t exp);
      vec_t v;
      v.rn = rn; v.op = op; v.mr = mr; v.z = z; v.exp = exp; v.name = name;
      vecs.push_back(v);
   endtask

   initial begin
      logic d;
      applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);

      // Directed table: reset, then one of each instruction class with mem_ready held high.
      addVec(0, 7'd0, 0, 0, "reset_outputs", '0);
      addVec(1, LW, 1, 0, "lw_fetch",   stepOut(SK_FETCH, 1, 0, 0, 0));
      addVec(1, LW, 1, 0, "lw_decode",  stepOut(SK_DECODE, 1, 0, 0, 0));
      addVec(1, LW, 1, 0, "lw_memadr",  stepOut(SK_ADDR, 1, 0, 0, 0));
      addVec(1, LW, 1, 0, "lw_memread", stepOut(SK_LOAD, 1, 0, 0, 0));
      addVec(1, LW, 1, 0, "lw_memwb",   stepOut(SK_LOADWB, 1, 0, 0, 1));
      addVec(1, SW, 1, 0, "sw_fetch",   stepOut(SK_FETCH, 1, 0, 0, 0));
      addVec(1, SW, 1, 0, "sw_decode",  stepOut(SK_DECODE, 1, 0, 0, 0));
      addVec(1, SW, 1, 0, "sw_memadr",  stepOut(SK_ADDR, 1, 0, 0, 0));
      addVec(1, SW, 1, 0, "sw_memwrite", stepOut(SK_STORE, 1, 0, 0, 1));
      addVec(1, BQ, 1, 1, "beq_fetch",  stepOut(SK_FETCH, 1, 1, 0, 0));
      addVec(1, BQ, 1, 1, "beq_decode", stepOut(SK_DECODE, 1, 1, 0, 0));
      addVec(1, BQ, 1, 1, "beq_taken",  stepOut(SK_BRANCH, 1, 1, 0, 1));
      addVec(1, BQ, 1, 0, "beqn_fetch", stepOut(SK_FETCH, 1, 0, 0, 0));
      addVec(1, BQ, 1, 0, "beqn_decode", stepOut(SK_DECODE, 1, 0, 0, 0));
      addVec(1, BQ, 1, 0, "beq_nottaken", stepOut(SK_BRANCH, 1, 0, 0, 1));
      addVec(1, RT, 1, 0, "r_fetch",    stepOut(SK_FETCH, 1, 0, 0, 0));
      addVec(1, RT, 1, 0, "r_decode",   stepOut(SK_DECODE, 1, 0, 0, 0));
      addVec(1, RT, 1, 0, "r_execute",  stepOut(SK_EXEC_R, 1, 0, 0, 0));
      addVec(1, RT, 1, 0, "r_aluwb",    stepOut(SK_ALUWB, 1, 0, 0, 1));
      addVec(1, IA, 1, 0, "i_fetch",    stepOut(SK_FETCH, 1, 0, 0, 0));
      addVec(1, IA, 1, 0, "i_decode",   stepOut(SK_DECODE, 1, 0, 0, 0));
      addVec(1, IA, 1, 0, "i_execute",  stepOut(SK_EXEC_I, 1, 0, 0, 0));
      addVec(1, IA, 1, 0, "i_aluwb",    stepOut(SK_ALUWB, 1, 0, 0, 1));
      addVec(1, 7'd0, 1, 0, "ill_fetch",  stepOut(SK_FETCH, 1, 0, 0, 0));
      addVec(1, 7'd0, 1, 0, "ill_decode", stepOut(SK_DECODE, 1, 0, 1, 1));
      addVec(1, JL, 1, 0, "jal_fetch",  stepOut(SK_FETCH, 1, 0, 0, 0));
      if (JAL_EN) begin
         addVec(1, JL, 1, 0, "jal_decode", stepOut(SK_DECODE, 1, 0, 0, 0));
         addVec(1, JL, 1, 0, "jal_jump",   stepOut(SK_JUMP, 1, 0, 0, 0));
         addVec(1, JL, 1, 0, "jal_aluwb",  stepOut(SK_ALUWB, 1, 0, 0, 1));
      end else begin
         addVec(1, JL, 1, 0, "jal_as_illegal", stepOut(SK_DECODE, 1, 0, 1, 1));
      end

      foreach (vecs[i])
         runCycle(vecs[i].rn, vecs[i].op, vecs[i].mr, vecs[i].z, vecs[i].name, vecs[i].exp, d);

      // Reset asserted while parked in MEMREAD, then FETCH waits three cycles for memory.
      runCycle(1, LW, 1, 0, "rs_fetch",    stepOut(SK_FETCH, 1, 0, 0, 0), d);
      runCycle(1, LW, 1, 0, "rs_decode",   stepOut(SK_DECODE, 1, 0, 0, 0), d);
      runCycle(1, LW, 1, 0, "rs_memadr",   stepOut(SK_ADDR, 1, 0, 0, 0), d);
      runCycle(1, LW, 0, 0, "rs_memread_wait", stepOut(SK_LOAD, 0, 0, 0, 0), d);
      runCycle(0, LW, 1, 1, "rs_in_reset", '0, d);
      for (int w = 0; w < 3; w++)
         runCycle(1, RT, 0, 0, "fetch_wait", stepOut(SK_FETCH, 0, 0, 0, 0), d);
      runCycle(1, RT, 1, 0, "fetch_ready", stepOut(SK_FETCH, 1, 0, 0, 0), d);
      runCycle(1, RT, 1, 0, "fw_decode",   stepOut(SK_DECODE, 1, 0, 0, 0), d);
      runCycle(1, RT, 0, 0, "fw_execute",  stepOut(SK_EXEC_R, 0, 0, 0, 0), d);
      runCycle(1, RT, 1, 0, "fw_aluwb",    stepOut(SK_ALUWB, 1, 0, 0, 1), d);

      // Randomized instructions: each becomes a list of steps; memory steps repeat until ready.
      for (int k = 0; k < 250; k++) begin
         logic [6:0] op;
         logic       ill, mr, z, waiting;
         int         waits, cyc, doneAt;
         case ($urandom_range(0, 7))
            0: op = LW;  1: op = SW;  2: op = RT;  3: op = IA;
            4: op = BQ;  5: op = JL;  6: op = 7'd0;
            default: op = 7'($urandom);
         endcase
         ill = 1'b0;
         case (op)
            LW: plan = {SK_FETCH, SK_DECODE, SK_ADDR, SK_LOAD, SK_LOADWB};
            SW: plan = {SK_FETCH, SK_DECODE, SK_ADDR, SK_STORE};
            RT: plan = {SK_FETCH, SK_DECODE, SK_EXEC_R, SK_ALUWB};
            IA: plan = {SK_FETCH, SK_DECODE, SK_EXEC_I, SK_ALUWB};
            BQ: plan = {SK_FETCH, SK_DECODE, SK_BRANCH};
            JL: if (JAL_EN) plan = {SK_FETCH, SK_DECODE, SK_JUMP, SK_ALUWB};
                else begin plan = {SK_FETCH, SK_DECODE}; ill = 1'b1; end
            default: begin plan = {SK_FETCH, SK_DECODE}; ill = 1'b1; end
         endcase
         waits = 0; cyc = 0; doneAt = -1;
         while (plan.size() > 0) begin
            mr = ($urandom_range(0, 3) != 0);
            z  = 1'($urandom_range(0, 1));
            waiting = (plan[0] inside {SK_FETCH, SK_LOAD, SK_STORE}) && !mr;
            runCycle(1, op, mr, z, "random_step",
                     stepOut(plan[0], mr, z, ill, (plan.size() == 1) && !waiting), d);
            cyc++;
            if (d === 1'b1 && doneAt < 0) doneAt = cyc;
            if (waiting) waits++;
            else void'(plan.pop_front());
         end
         assertCount++;
         if (doneAt != cpi(op) + waits) begin
            failCount++;
            $display("[TB] FAIL random_cpi op=%b: actual=%0d required=%0d", op, doneAt, cpi(op) + waits);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the datapath mux selects and write enables. Produces the 2-bit `ALUOp` consumed by the ALU control decoder, which turns it into the 4-bit ALU operation. Sits between the instruction register's opcode field and the datapath, with a ready handshake to the unified instruction/data memory.

## Interface
Parameters: none.

- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `opcode` in 7: `instr[6:0]` from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `ALUOp` out 2: 00 add, 01 subtract, 10 decode by funct.
- `alu_src_a` out 2: 00 PC, 01 oldPC, 10 rs1.
- `alu_src_b` out 2: 00 rs2, 01 imm, 10 constant 4.
- `result_src` out 2: 00 ALUOut, 01 memory data, 10 ALU result.
- `adr_src` out 1: memory address select, 0 PC, 1 result.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: load IR and oldPC.
- `pc_write` out 1: load PC.
- `reg_write` out 1: register file write.
- `illegal_instr` out 1: unrecognised opcode seen in DECODE.
- `instr_done` out 1: last cycle of an instruction.

## Operation
- Opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - beq 1100011
  - jal 1101111
- States and transitions:
  - FETCH → DECODE when `mem_ready`=1; otherwise stay in FETCH.
  - DECODE → MEMADR for lw or sw.
  - DECODE → EXECUTER for R-type.
  - DECODE → EXECUTEI for I-ALU.
  - DECODE → BEQ for beq.
  - DECODE → JAL for jal.
  - DECODE → FETCH for any other opcode.
  - MEMADR → MEMREAD for lw; MEMADR → MEMWRITE for sw.
  - MEMREAD → MEMWB when `mem_ready`=1; otherwise stay.
  - MEMWRITE → FETCH when `mem_ready`=1; otherwise stay.
  - EXECUTER → ALUWB; EXECUTEI → ALUWB; JAL → ALUWB.
  - MEMWB → FETCH; ALUWB → FETCH; BEQ → FETCH.
- Moore outputs per state. Every output not listed for a state is 0.
  - FETCH: `mem_read`=1; `alu_src_b`=10; `result_src`=10; `ALUOp`=00. `ir_write` and `pc_write` equal `mem_ready`.
  - DECODE: `alu_src_a`=01; `alu_src_b`=01; `ALUOp`=00. This precomputes the branch target.
  - MEMADR: `alu_src_a`=10; `alu_src_b`=01; `ALUOp`=00.
  - MEMREAD: `adr_src`=1; `mem_read`=1.
  - MEMWRITE: `adr_src`=1; `mem_write`=1.
  - MEMWB: `result_src`=01; `reg_write`=1.
  - EXECUTER: `alu_src_a`=10; `alu_src_b`=00; `ALUOp`=10.
  - EXECUTEI: `alu_src_a`=10; `alu_src_b`=01; `ALUOp`=10.
  - ALUWB: `reg_write`=1.
  - BEQ: `alu_src_a`=10; `ALUOp`=01; `pc_write`=`zero`.
  - JAL: `alu_src_a`=01; `alu_src_b`=10; `pc_write`=1. This writes the target held in ALUOut to the PC.
- `illegal_instr`=1 only in DECODE when the opcode is unrecognised.
- `instr_done`=1 in the cycle whose next state is FETCH. This includes the illegal-opcode DECODE cycle.
- `mem_read` and `mem_write` are held steady while the FSM waits for `mem_ready`.

## Timing
- Cycles per instruction with `mem_ready` held at 1:
  - lw 5
  - sw 4
  - R-type 4
  - I-ALU 4
  - jal 4
  - beq 3
  - illegal 2
- Each wait cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset:
  - `rst_n`=0 sampled at a clock edge sets the state to FETCH, from any state.
  - While `rst_n`=0, all outputs are forced to 0, including `mem_read`.
  - The first FETCH request appears in the first cycle after `rst_n` rises.
- A `mem_ready` pulse in a state with no memory request is ignored.

## Configuration
- Macro `MC_CTRL_JAL_EN`.
- Defined: JAL state and jal decode are present, as described above.
- Undefined: JAL state is not built. Opcode 1101111 is treated as illegal: DECODE → FETCH with `illegal_instr`=1.

## Structure
- Package `mc_ctrl_pkg`:
  - `state_t` enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWRITE, MEMWB, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
  - Opcode localparams.
  - `ALUOp` constants: ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_FUNCT=2'b10.
  - Mux-select constants.
- Optional sub-module `mc_ctrl_outdec`: purely combinational, maps state, `mem_ready` and `zero` to outputs. The top module holds the state register and next-state logic.

## Test plan
1. Reset: drive `rst_n`=0 for one edge while in MEMREAD → all outputs 0 during reset; FETCH with `mem_read`=1 on the cycle after release.
2. lw (0000011) with `mem_ready`=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `reg_write`=1 with `result_src`=01 in cycle 5, together with `instr_done`=1.
3. FETCH wait: `mem_ready`=0 for 3 cycles → state stays FETCH, `ir_write`=`pc_write`=0. On the 4th cycle with `mem_ready`=1 → `ir_write`=`pc_write`=1, then DECODE.
4. beq (1100011) → BEQ state has `ALUOp`=01. With `zero`=1, `pc_write`=1; with `zero`=0, `pc_write`=0. Both cases take 3 cycles.
5. R-type (0110011) → EXECUTER with `ALUOp`=10 and `alu_src_b`=00; ALUWB with `reg_write`=1. I-ALU (0010011) → `alu_src_b`=01.
6. Opcode 0000000 → `illegal_instr`=1 and `instr_done`=1 in DECODE, then FETCH. Opcode 1101111 with `MC_CTRL_JAL_EN` → JAL with `pc_write`=1, then ALUWB. Without the macro → handled as illegal.
